// File: rtl/spike_rate_encoder.sv
// spike_rate_encoder
//    Rate encoder: converts a WIDTH-bit stimulus intensity into a spike train
//    lasting N cycles. A phase accumulator sets the spike density: each RUN
//    cycle adds value_reg to acc, and the carry out is the spike. This gives
//    floor(N*value/2^WIDTH) spikes per window.
//
//    Optional feature: define SPIKE_LFSR_EN to add the mode_stoch port and a
//    16-bit LFSR (seed 16'hACE1). With mode_stoch=1, spikes are drawn by
//    comparing the LFSR low bits against value_reg.
//
// Ports
//    clk          rising-edge clock
//    rst_n        synchronous reset, active-low
//    in_valid     stimulus offered
//    in_ready     encoder idle and able to accept a stimulus
//    in_value     stimulus intensity, sampled on acceptance
//    in_window    window length N in cycles (0 means 2^WINDOW_W)
//    mode_stoch   (SPIKE_LFSR_EN only) stochastic mode, sampled on acceptance
//    abort        terminates the current window
//    spike_out    one-cycle spikes, only in RUN
//    busy         high while a window runs
//    done         one-cycle pulse after a window completes normally
//    spike_count  spikes emitted in the current or last window
//
// state  | meaning
// -------+---------------------------------------------------------
// S_IDLE | waiting for a stimulus; in_ready=1; done may pulse here
// S_RUN  | emitting the spike train for the remaining window cycles

module spike_rate_encoder #(
   parameter int WIDTH    = 8,
   parameter int WINDOW_W = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [WIDTH-1:0]    in_value,
   input  logic [WINDOW_W-1:0] in_window,
`ifdef SPIKE_LFSR_EN
   input  logic                mode_stoch,
`endif
   input  logic                abort,
   output logic                spike_out,
   output logic                busy,
   output logic                done,
   output logic [WINDOW_W-1:0] spike_count
);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   // Remaining-cycle counter is one bit wider so that a window of 2^WINDOW_W
   // cycles can be loaded directly.
   localparam logic [WINDOW_W:0] FULL_WINDOW = {1'b1, {WINDOW_W{1'b0}}};
   localparam logic [WINDOW_W:0] LAST_CYCLE  = {{WINDOW_W{1'b0}}, 1'b1};

   state_t              state, state_nxt;
   logic [WIDTH-1:0]    value_reg;
   logic [WIDTH-1:0]    acc;
   logic [WINDOW_W:0]   remaining;
   logic [WINDOW_W-1:0] count_q;
   logic                done_q;

   logic [WIDTH:0]      sum;
   logic                spike_raw;
   logic                run_step;
   logic                accept;
   logic                window_end;

   assign sum        = {1'b0, acc} + {1'b0, value_reg};
   assign in_ready   = (state == S_IDLE);
   assign accept     = in_valid && in_ready;
   // Abort freezes the window for that cycle: no spike, no count, no update.
   assign run_step   = (state == S_RUN) && !abort;
   assign window_end = run_step && (remaining == LAST_CYCLE);

`ifdef SPIKE_LFSR_EN
   logic [15:0] lfsr;
   logic        lfsr_fb;
   logic        stoch_reg;

   assign lfsr_fb   = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
   assign spike_raw = stoch_reg ? (lfsr[WIDTH-1:0] < value_reg) : sum[WIDTH];

   // Free-running across windows; only RUN cycles without abort advance it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lfsr      <= 16'hACE1;
         stoch_reg <= 1'b0;
      end else begin
         if (accept)
            stoch_reg <= mode_stoch;
         if (run_step)
            lfsr <= {lfsr_fb, lfsr[15:1]};
      end
   end
`else
   assign spike_raw = sum[WIDTH];
`endif

   assign spike_out   = run_step && spike_raw;
   assign busy        = (state == S_RUN);
   assign done        = done_q;
   assign spike_count = count_q;

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (accept) state_nxt = S_RUN;
         S_RUN: begin
            if (abort || window_end)
               state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         value_reg <= '0;
         acc       <= '0;
         remaining <= '0;
         count_q   <= '0;
         done_q    <= 1'b0;
      end else begin
         state  <= state_nxt;
         done_q <= window_end;
         if (accept) begin
            value_reg <= in_value;
            remaining <= (in_window == '0) ? FULL_WINDOW : {1'b0, in_window};
            acc       <= '0;
            count_q   <= '0;
         end else if (run_step) begin
            acc       <= sum[WIDTH-1:0];
            remaining <= remaining - LAST_CYCLE;
            if (spike_out)
               count_q <= count_q + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_spike_rate_encoder.sv
module tb_spike_rate_encoder;
   localparam int W  = 8;
   localparam int WW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_value;
   logic [WW-1:0] in_window;
   logic          mode_stoch;
   logic          abort;
   logic          spike_out;
   logic          busy;
   logic          done;
   logic [WW-1:0] spike_count;

   always #5 clk = ~clk;

   spike_rate_encoder #(.WIDTH(W), .WINDOW_W(WW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_value   (in_value),
      .in_window  (in_window),
`ifdef SPIKE_LFSR_EN
      .mode_stoch (mode_stoch),
`endif
      .abort      (abort),
      .spike_out  (spike_out),
      .busy       (busy),
      .done       (done),
      .spike_count(spike_count)
   );

   int checks = 0;
   int passed = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Behavioural model: a window is a sequence of N cycles; cycle k carries a
   // spike when floor((k+1)*v/2^W) exceeds floor(k*v/2^W).
   bit          m_valid = 0;
   bit          m_run, m_done, m_stoch;
   int          m_k, m_n, m_v, m_cnt;
   logic [15:0] m_lfsr;
   int          spk_q[$];

   function automatic bit det_spike(input int k, input int v);
      return ((((k + 1) * v) >> W) != ((k * v) >> W));
   endfunction

   function automatic bit exp_spike();
      if (!m_run || abort) return 1'b0;
      if (m_stoch) return (int'(m_lfsr[W-1:0]) < m_v);
      return det_spike(m_k, m_v);
   endfunction

   always @(posedge clk) begin
      bit sp, nd;
      if (!rst_n) begin
         m_valid = 1; m_run = 0; m_done = 0; m_stoch = 0;
         m_k = 0; m_n = 0; m_v = 0; m_cnt = 0; m_lfsr = 16'hACE1;
      end else if (m_valid) begin
         sp = exp_spike();
         nd = 0;
         if (m_run) begin
            if (abort) m_run = 0;
            else begin
               if (sp) m_cnt++;
               m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
               m_k++;
               if (m_k == m_n) begin m_run = 0; nd = 1; end
            end
         end else if (in_valid) begin
            m_run = 1; m_k = 0; m_v = int'(in_value);
            m_n = (in_window == 0) ? (1 << WW) : int'(in_window);
            m_cnt = 0;
`ifdef SPIKE_LFSR_EN
            m_stoch = mode_stoch;
`endif
         end
         m_done = nd;
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         check("in_ready",    int'(in_ready),    int'(!m_run));
         check("busy",        int'(busy),        int'(m_run));
         check("done",        int'(done),        int'(m_done));
         check("spike_out",   int'(spike_out),   int'(exp_spike()));
         check("spike_count", int'(spike_count), m_cnt);
         if (m_run && spike_out) spk_q.push_back(m_k);
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic wait_ready();
      for (int i = 0; i < 600 && !in_ready; i++) step();
      check("ready_timeout", int'(in_ready), 1);
   endtask

   // Offers one stimulus and runs its window; abort_at<0 means no abort.
   task automatic run_window(input int v, input int n, input int abort_at, input bit junk);
      int n_eff;
      n_eff = (n == 0) ? (1 << WW) : n;
      wait_ready();
      in_valid = 1; in_value = W'(v); in_window = WW'(n);
      step();
      in_valid = 0;
      for (int k = 0; k < n_eff; k++) begin
         abort = (k == abort_at);
         if (junk) begin
            in_value  = W'($urandom);
            in_window = WW'($urandom);
            in_valid  = (k < n_eff - 1) ? 1'($urandom) : 1'b0;
         end
         step();
         if (k == abort_at) break;
      end
      abort = 0; in_valid = 0;
   endtask

   initial begin
      int v, n, ab;
      rst_n = 0; in_valid = 0; in_value = 0; in_window = 0; abort = 0; mode_stoch = 0;
      step(); step();
      check("rst_ready", int'(in_ready), 1);
      check("rst_count", int'(spike_count), 0);
      rst_n = 1;
      step();

      // value=64, N=16: spikes at 3,7,11,15
      spk_q.delete();
      run_window(64, 16, -1, 0);
      check("t1_done", int'(done), 1);
      check("t1_done_ready", int'(in_ready), 1);
      check("t1_count", int'(spike_count), 4);
      check("t1_model_count", m_cnt, 4);
      check("t1_nspikes", spk_q.size(), 4);
      if (spk_q.size() == 4) begin
         check("t1_sp0", spk_q[0], 3);  check("t1_sp1", spk_q[1], 7);
         check("t1_sp2", spk_q[2], 11); check("t1_sp3", spk_q[3], 15);
      end
      step();
      check("t1_done_pulse", int'(done), 0);

      // value=0, N=10
      spk_q.delete();
      run_window(0, 10, -1, 1);
      check("t2_done", int'(done), 1);
      check("t2_count", int'(spike_count), 0);
      check("t2_nspikes", spk_q.size(), 0);
      step();

      // value=255, N=0 (256 cycles)
      spk_q.delete();
      run_window(255, 0, -1, 1);
      check("t3_done", int'(done), 1);
      check("t3_count", int'(spike_count), 255);
      check("t3_first_spike", (spk_q.size() > 0) ? spk_q[0] : -1, 1);
      step();

      // in_valid held across a window
      in_valid = 1; in_value = 128; in_window = 4;
      step();
      for (int k = 0; k < 4; k++) begin
         check("t4_not_ready", int'(in_ready), 0);
         step();
      end
      check("t4_done", int'(done), 1);
      check("t4_done_ready", int'(in_ready), 1);
      step();
      in_valid = 0;
      check("t4_rerun_busy", int'(busy), 1);
      check("t4_rerun_count", int'(spike_count), 0);
      for (int k = 0; k < 4; k++) step();
      step();

      // abort in RUN cycle 5 of value=128, N=20
      spk_q.delete();
      run_window(128, 20, 5, 0);
      check("t5_idle", int'(in_ready), 1);
      check("t5_no_done", int'(done), 0);
      check("t5_count", int'(spike_count), 2);
      check("t5_nspikes", spk_q.size(), 2);
      step();
      check("t5_count_hold", int'(spike_count), 2);

      // abort together with in_valid in IDLE: accepted
      in_valid = 1; abort = 1; in_value = 10; in_window = 3;
      step();
      in_valid = 0; abort = 0;
      check("t6_accept_abort", int'(busy), 1);
      for (int k = 0; k < 4; k++) step();

      // reset in RUN cycle 7 of value=200
      wait_ready();
      in_valid = 1; in_value = 200; in_window = 30;
      step();
      in_valid = 0;
      for (int k = 0; k < 7; k++) step();
      rst_n = 0;
      step();
      check("t7_ready", int'(in_ready), 1);
      check("t7_busy", int'(busy), 0);
      check("t7_done", int'(done), 0);
      check("t7_spike", int'(spike_out), 0);
      check("t7_count", int'(spike_count), 0);
      rst_n = 1;
      step();

      // randomized windows
      for (int it = 0; it < 40; it++) begin
         v  = $urandom_range(0, (1 << W) - 1);
         n  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 40);
         ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, ((n == 0) ? 256 : n) - 1) : -1;
         run_window(v, n, ab, 1);
         for (int g = $urandom_range(0, 3); g > 0; g--) begin
            abort = 1'($urandom);
            step();
         end
         abort = 0;
      end

`ifdef SPIKE_LFSR_EN
      // stochastic mode; model carries LFSR state across windows
      wait_ready();
      mode_stoch = 1;
      run_window(128, 0, -1, 0);
      mode_stoch = 0;
      check("t8_count_range", int'(spike_count >= 108 && spike_count <= 148), 1);
`endif

      step();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/spike_rate_encoder.md
Name: spike_rate_encoder

Overview:
Rate encoder that converts a WIDTH-bit stimulus intensity into a spike train of programmable window length. It drives the single-bit spike input of the LIF neuron array and is the transmit side of the spike link. A deterministic phase accumulator sets spike density: spikes per window = floor(N*value/2^WIDTH). Stimuli arrive over a valid/ready handshake; completion is reported by a done pulse and a spike count.

Parameters:
WIDTH, 8, stimulus intensity width and accumulator width; legal range 2..16
WINDOW_W, 8, window-length field width and spike_count width

Ports:
clk  input  1  clock; all logic on the rising edge
rst_n  input  1  synchronous reset, active-low
in_valid  input  1  stimulus offered
in_ready  output  1  encoder can accept a stimulus; equals (state==IDLE)
in_value  input  WIDTH  intensity, sampled on acceptance
in_window  input  WINDOW_W  window length N in cycles; 0 means 2^WINDOW_W
abort  input  1  terminates the current window
spike_out  output  1  spike train to the neuron; one cycle per spike
busy  output  1  high in RUN
done  output  1  one-cycle pulse when a window completes normally
spike_count  output  WINDOW_W  spikes emitted in the current or last window

Behaviour:
- Reset: clk and rst_n are decided as above (synchronous, active-low reset). After the reset edge: state=IDLE, in_ready=1, busy=0, done=0, spike_out=0, spike_count=0, accumulator=0, window counter=0. Reset during RUN discards the window; no done pulse.
- States: IDLE and RUN.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch in_value into value_reg; load the remaining-cycle counter with N (0 maps to 2^WINDOW_W); clear acc and spike_count; go to RUN on the next edge.
- RUN:
  - Each cycle, {carry,sum} = acc + value_reg, computed at WIDTH+1 bits. acc <= sum, so it wraps modulo 2^WIDTH.
  - spike_out = carry, combinational from registered state, gated by RUN.
  - spike_count increments on each spike.
  - The counter decrements every cycle. RUN lasts exactly N cycles.
- Window end: after the Nth RUN cycle the state returns to IDLE. done=1 for exactly that first IDLE cycle, and in_ready=1 in the same cycle, so back-to-back stimuli lose no cycle.
- Data capture: in_value and in_window changes during RUN are ignored. in_valid during RUN is not accepted (in_ready=0).
- Abort:
  - abort in RUN has priority. That cycle: spike_out forced 0, no count, no acc update.
  - Next state is IDLE with no done pulse. spike_count holds the partial count.
  - abort in IDLE is ignored. abort together with in_valid in IDLE: the stimulus is accepted.
- spike_count holds its value in IDLE until the next acceptance clears it.
- Boundaries:
  - value=0 gives no spikes.
  - value=2^WIDTH-1 gives a spike every RUN cycle except the first.
  - Count never exceeds N-1, so it always fits in WINDOW_W bits.
- No spike is emitted outside RUN.

Optional Feature:
- Macro SPIKE_LFSR_EN. When defined:
  - Adds input port mode_stoch (1 bit), sampled on acceptance.
  - Adds a 16-bit Fibonacci LFSR with taps x^16+x^14+x^13+x^11+1, seeded to 16'hACE1 on reset. It advances only in RUN cycles without abort and is never re-seeded between windows.
  - With mode_stoch=1, spike_out = (lfsr[WIDTH-1:0] < value_reg), giving Poisson-like encoding. With mode_stoch=0, behaviour is the deterministic accumulator.
- When not defined: mode_stoch port and LFSR are absent; deterministic only.

Test Plan:
- value=64, window=16 -> spikes in RUN cycles 3,7,11,15 (0-indexed); spike_count=4; done one cycle after RUN cycle 15, with in_ready=1 in that cycle.
- value=0, window=10 -> spike_out never high; busy for 10 cycles; done pulse; spike_count=0.
- value=255, window=0 -> RUN lasts 256 cycles; no spike in RUN cycle 0, spike in every cycle from 1 to 255; spike_count=255.
- in_valid held high with value=128, window=4 across a window -> second stimulus not accepted during RUN; accepted in the done cycle; second RUN starts the next cycle with spike_count cleared.
- value=128, window=20, abort in RUN cycle 5 -> spikes at cycles 1,3 only; IDLE next cycle; no done; spike_count holds 2.
- rst_n low in RUN cycle 7 of a value=200 window -> after the edge all outputs at reset values, in_ready=1. With SPIKE_LFSR_EN, mode_stoch=1, value=128, window=0 -> spike_count in 108..148, and the first eight spike_out bits match a reference LFSR model seeded 16'hACE1.
